jump_rs_scheduler: RTL and testbench

- Reservation station and issue scheduler for the branch/jump functional unit in the Tomasulo core.
- Accepts dispatched branch/JAL/JALR ops with renamed operands and snoops the CDB to capture operand values.
- Picks the oldest ready entry and issues it to the single branch FU, keeping at most one op in flight.
- Frees the FU slot on the FU's done indication; `flush` (mispredict recovery) discards all waiting entries.

---
 rtl/tomasulo_pkg.sv | 32 +++
 rtl/age_matrix_picker.sv | 54 +++++
 rtl/jump_rs_scheduler.sv | 273 +++++++++++++++++++++++++++
 tb/tb_jump_rs_scheduler.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: default widths, tag encoding, branch compare
// codes, issue FSM states and a one-hot helper.
package tomasulo_pkg;

    localparam int unsigned TAG_W          = 4;
    localparam int unsigned XLEN           = 32;
    localparam int unsigned TAG_NONE       = 0;
    localparam int unsigned MAX_RS_ENTRIES = 8;

    typedef enum logic [2:0] {
        CMP_UNCOND = 3'd0,
        CMP_EQ     = 3'd1,
        CMP_NE     = 3'd2,
        CMP_LT     = 3'd3,
        CMP_GE     = 3'd4,
        CMP_LTU    = 3'd5,
        CMP_GEU    = 3'd6
    } cmp_ctrl_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } issue_state_e;

    // Isolate the lowest set bit of a vector (priority allocation helper).
    function automatic logic [MAX_RS_ENTRIES-1:0] lowest_one_hot(
        input logic [MAX_RS_ENTRIES-1:0] vec
    );
        return vec & (~vec + MAX_RS_ENTRIES'(1));
    endfunction

endpackage

// File: rtl/age_matrix_picker.sv
// Age matrix for the reservation station: tracks relative entry age and
// returns the oldest ready entry as a one-hot grant.
// r_age[i][j] == 1 means entry i is younger than entry j.
module age_matrix_picker #(
    parameter int unsigned NUM_ENTRIES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic [NUM_ENTRIES-1:0] i_valid,
    input  logic [NUM_ENTRIES-1:0] i_alloc_oh,
    input  logic [NUM_ENTRIES-1:0] i_free_oh,
    input  logic [NUM_ENTRIES-1:0] i_ready,
    output logic [NUM_ENTRIES-1:0] o_grant_oh_c,
    output logic                   o_grant_valid_c
);

    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] r_age;
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] w_age_nxt;

    // Next matrix: new row on allocation, freed columns cleared, flush wipes all.
    always_comb begin
        w_age_nxt = r_age;
        for (int unsigned r = 0; r < NUM_ENTRIES; r++) begin
            if (i_alloc_oh[r]) begin
                w_age_nxt[r] = i_valid & ~i_free_oh;
            end else begin
                w_age_nxt[r] = r_age[r] & ~i_free_oh;
            end
        end
        if (i_flush) begin
            w_age_nxt = '0;
        end
    end

    // Age matrix register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_age <= '0;
        end else begin
            r_age <= w_age_nxt;
        end
    end

    // Oldest ready: a ready entry with no older ready entry.
    always_comb begin
        o_grant_oh_c = '0;
        for (int unsigned r = 0; r < NUM_ENTRIES; r++) begin
            o_grant_oh_c[r] = i_ready[r] & ~|(r_age[r] & i_ready);
        end
        o_grant_valid_c = |o_grant_oh_c;
    end

endmodule

// File: rtl/jump_rs_scheduler.sv
// Reservation station and single-issue scheduler for the branch/jump FU.
// Captures operands from the CDB, issues the oldest ready op while the FU is
// free and keeps at most one op in flight.
module jump_rs_scheduler
    import tomasulo_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned TAG_W       = tomasulo_pkg::TAG_W,
    parameter int unsigned XLEN        = tomasulo_pkg::XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    // dispatch
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic             disp_jalr,
    input  logic [2:0]       disp_cmp_ctrl,
    input  logic [XLEN-1:0]  disp_imm,
    input  logic [XLEN-1:0]  disp_pc,
    input  logic [TAG_W-1:0] disp_dst_tag,
    input  logic [TAG_W-1:0] disp_rs1_tag,
    input  logic [XLEN-1:0]  disp_rs1_val,
    input  logic [TAG_W-1:0] disp_rs2_tag,
    input  logic [XLEN-1:0]  disp_rs2_val,
    // common data bus
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    // FU issue
    output logic             fu_en,
    output logic             fu_jalr,
    output logic [2:0]       fu_cmp_ctrl,
    output logic [XLEN-1:0]  fu_rs1_data,
    output logic [XLEN-1:0]  fu_rs2_data,
    output logic [XLEN-1:0]  fu_imm,
    output logic [XLEN-1:0]  fu_pc,
    output logic [TAG_W-1:0] fu_tag,
    input  logic             fu_done,
    // control / status
    input  logic             flush,
    output logic             fu_busy,
    output logic             rs_empty
);

    localparam logic [TAG_W-1:0] W_TAG_NONE = TAG_W'(TAG_NONE);

    // entry storage
    logic [NUM_ENTRIES-1:0] r_valid;
    logic [NUM_ENTRIES-1:0] r_jalr;
    cmp_ctrl_e              r_cmp [NUM_ENTRIES];
    logic [XLEN-1:0]        r_imm [NUM_ENTRIES];
    logic [XLEN-1:0]        r_pc  [NUM_ENTRIES];
    logic [TAG_W-1:0]       r_dst [NUM_ENTRIES];
    logic [TAG_W-1:0]       r_q1  [NUM_ENTRIES];
    logic [XLEN-1:0]        r_v1  [NUM_ENTRIES];
    logic [TAG_W-1:0]       r_q2  [NUM_ENTRIES];
    logic [XLEN-1:0]        r_v2  [NUM_ENTRIES];

    // issue FSM and registered FU outputs
    issue_state_e           r_state;
    issue_state_e           w_state_nxt;
    logic                   w_issue;
    logic                   r_fu_en;
    logic                   r_fu_busy;
    logic                   r_fu_jalr;
    logic [2:0]             r_fu_cmp;
    logic [XLEN-1:0]        r_fu_rs1;
    logic [XLEN-1:0]        r_fu_rs2;
    logic [XLEN-1:0]        r_fu_imm;
    logic [XLEN-1:0]        r_fu_pc;
    logic [TAG_W-1:0]       r_fu_tag;

    // combinational control
    logic                   w_disp_ready;
    logic                   w_disp_fire;
    logic [NUM_ENTRIES-1:0] w_alloc_oh;
    logic [NUM_ENTRIES-1:0] w_ready;
    logic [NUM_ENTRIES-1:0] w_grant_oh;
    logic                   w_grant_valid;
    logic [NUM_ENTRIES-1:0] w_issue_oh;
    logic                   w_byp1;
    logic                   w_byp2;
    logic [TAG_W-1:0]       w_new_q1;
    logic [XLEN-1:0]        w_new_v1;
    logic [TAG_W-1:0]       w_new_q2;
    logic [XLEN-1:0]        w_new_v2;
    logic                   w_sel_jalr;
    logic [2:0]             w_sel_cmp;
    logic [XLEN-1:0]        w_sel_rs1;
    logic [XLEN-1:0]        w_sel_rs2;
    logic [XLEN-1:0]        w_sel_imm;
    logic [XLEN-1:0]        w_sel_pc;
    logic [TAG_W-1:0]       w_sel_tag;

    // Dispatch acceptance and lowest-index free-slot allocation (registered state only).
    always_comb begin
        w_disp_ready = ~&r_valid;
        w_disp_fire  = disp_valid & w_disp_ready & ~flush;
        w_alloc_oh   = '0;
        if (w_disp_fire) begin
            w_alloc_oh = NUM_ENTRIES'(lowest_one_hot(MAX_RS_ENTRIES'(~r_valid)));
        end
    end

    // Same-cycle CDB bypass onto the dispatched operands.
    always_comb begin
        w_byp1   = cdb_valid && (disp_rs1_tag != W_TAG_NONE) && (cdb_tag == disp_rs1_tag);
        w_byp2   = cdb_valid && (disp_rs2_tag != W_TAG_NONE) && (cdb_tag == disp_rs2_tag);
        w_new_q1 = w_byp1 ? W_TAG_NONE : disp_rs1_tag;
        w_new_v1 = w_byp1 ? cdb_data   : disp_rs1_val;
        w_new_q2 = w_byp2 ? W_TAG_NONE : disp_rs2_tag;
        w_new_v2 = w_byp2 ? cdb_data   : disp_rs2_val;
    end

    // Ready vector from registered entry state.
    always_comb begin
        w_ready = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            w_ready[i] = r_valid[i] && (r_q1[i] == W_TAG_NONE) && (r_q2[i] == W_TAG_NONE);
        end
    end

    age_matrix_picker #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_picker (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_flush         (flush),
        .i_valid         (r_valid),
        .i_alloc_oh      (w_alloc_oh),
        .i_free_oh       (w_issue_oh),
        .i_ready         (w_ready),
        .o_grant_oh_c    (w_grant_oh),
        .o_grant_valid_c (w_grant_valid)
    );

    // Issue FSM next state: issue from IDLE, wait for fu_done in BUSY.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (fu_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_issue_oh = w_issue ? w_grant_oh : '0;
    end

    // One-hot mux of the granted entry's fields.
    always_comb begin
        w_sel_jalr = 1'b0;
        w_sel_cmp  = '0;
        w_sel_rs1  = '0;
        w_sel_rs2  = '0;
        w_sel_imm  = '0;
        w_sel_pc   = '0;
        w_sel_tag  = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            w_sel_jalr = w_sel_jalr | (r_jalr[i] & w_grant_oh[i]);
            w_sel_cmp  = w_sel_cmp  | (3'(r_cmp[i]) & {3{w_grant_oh[i]}});
            w_sel_rs1  = w_sel_rs1  | (r_v1[i]  & {XLEN{w_grant_oh[i]}});
            w_sel_rs2  = w_sel_rs2  | (r_v2[i]  & {XLEN{w_grant_oh[i]}});
            w_sel_imm  = w_sel_imm  | (r_imm[i] & {XLEN{w_grant_oh[i]}});
            w_sel_pc   = w_sel_pc   | (r_pc[i]  & {XLEN{w_grant_oh[i]}});
            w_sel_tag  = w_sel_tag  | (r_dst[i] & {TAG_W{w_grant_oh[i]}});
        end
    end

    // Issue FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered FU interface; data holds until the next issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fu_en   <= 1'b0;
            r_fu_busy <= 1'b0;
            r_fu_jalr <= 1'b0;
            r_fu_cmp  <= '0;
            r_fu_rs1  <= '0;
            r_fu_rs2  <= '0;
            r_fu_imm  <= '0;
            r_fu_pc   <= '0;
            r_fu_tag  <= '0;
        end else begin
            r_fu_en   <= w_issue;
            r_fu_busy <= (w_state_nxt == ST_BUSY);
            if (w_issue) begin
                r_fu_jalr <= w_sel_jalr;
                r_fu_cmp  <= w_sel_cmp;
                r_fu_rs1  <= w_sel_rs1;
                r_fu_rs2  <= w_sel_rs2;
                r_fu_imm  <= w_sel_imm;
                r_fu_pc   <= w_sel_pc;
                r_fu_tag  <= w_sel_tag;
            end
        end
    end

    // Entry update: flush, allocation, free on issue, CDB wakeup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_jalr  <= '0;
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                r_cmp[i] <= CMP_UNCOND;
                r_imm[i] <= '0;
                r_pc[i]  <= '0;
                r_dst[i] <= '0;
                r_q1[i]  <= '0;
                r_v1[i]  <= '0;
                r_q2[i]  <= '0;
                r_v2[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                if (flush) begin
                    r_valid[i] <= 1'b0;
                end else if (w_alloc_oh[i]) begin
                    r_valid[i] <= 1'b1;
                    r_jalr[i]  <= disp_jalr;
                    r_cmp[i]   <= cmp_ctrl_e'(disp_cmp_ctrl);
                    r_imm[i]   <= disp_imm;
                    r_pc[i]    <= disp_pc;
                    r_dst[i]   <= disp_dst_tag;
                    r_q1[i]    <= w_new_q1;
                    r_v1[i]    <= w_new_v1;
                    r_q2[i]    <= w_new_q2;
                    r_v2[i]    <= w_new_v2;
                end else begin
                    if (w_issue_oh[i]) begin
                        r_valid[i] <= 1'b0;
                    end
                    if (r_valid[i] && cdb_valid && (r_q1[i] != W_TAG_NONE) && (r_q1[i] == cdb_tag)) begin
                        r_q1[i] <= W_TAG_NONE;
                        r_v1[i] <= cdb_data;
                    end
                    if (r_valid[i] && cdb_valid && (r_q2[i] != W_TAG_NONE) && (r_q2[i] == cdb_tag)) begin
                        r_q2[i] <= W_TAG_NONE;
                        r_v2[i] <= cdb_data;
                    end
                end
            end
        end
    end

    assign disp_ready  = w_disp_ready;
    assign rs_empty    = ~|r_valid;
    assign fu_en       = r_fu_en;
    assign fu_busy     = r_fu_busy;
    assign fu_jalr     = r_fu_jalr;
    assign fu_cmp_ctrl = r_fu_cmp;
    assign fu_rs1_data = r_fu_rs1;
    assign fu_rs2_data = r_fu_rs2;
    assign fu_imm      = r_fu_imm;
    assign fu_pc       = r_fu_pc;
    assign fu_tag      = r_fu_tag;

endmodule

// File: tb/tb_jump_rs_scheduler.sv
// Self-checking bench for jump_rs_scheduler: vector table of single ops plus
// hand-written age-order, full/flush and async-reset sequences. Expected issues
// are queued at dispatch and compared by a monitor when fu_en fires.
module tb_jump_rs_scheduler;

    logic        clk;
    logic        rst_n;
    logic        disp_valid;
    logic        disp_ready;
    logic        disp_jalr;
    logic [2:0]  disp_cmp_ctrl;
    logic [31:0] disp_imm;
    logic [31:0] disp_pc;
    logic [3:0]  disp_dst_tag;
    logic [3:0]  disp_rs1_tag;
    logic [31:0] disp_rs1_val;
    logic [3:0]  disp_rs2_tag;
    logic [31:0] disp_rs2_val;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        fu_en;
    logic        fu_jalr;
    logic [2:0]  fu_cmp_ctrl;
    logic [31:0] fu_rs1_data;
    logic [31:0] fu_rs2_data;
    logic [31:0] fu_imm;
    logic [31:0] fu_pc;
    logic [3:0]  fu_tag;
    logic        fu_done;
    logic        flush;
    logic        fu_busy;
    logic        rs_empty;

    jump_rs_scheduler #(
        .NUM_ENTRIES (4),
        .TAG_W       (4),
        .XLEN        (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_jalr     (disp_jalr),
        .disp_cmp_ctrl (disp_cmp_ctrl),
        .disp_imm      (disp_imm),
        .disp_pc       (disp_pc),
        .disp_dst_tag  (disp_dst_tag),
        .disp_rs1_tag  (disp_rs1_tag),
        .disp_rs1_val  (disp_rs1_val),
        .disp_rs2_tag  (disp_rs2_tag),
        .disp_rs2_val  (disp_rs2_val),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .fu_en         (fu_en),
        .fu_jalr       (fu_jalr),
        .fu_cmp_ctrl   (fu_cmp_ctrl),
        .fu_rs1_data   (fu_rs1_data),
        .fu_rs2_data   (fu_rs2_data),
        .fu_imm        (fu_imm),
        .fu_pc         (fu_pc),
        .fu_tag        (fu_tag),
        .fu_done       (fu_done),
        .flush         (flush),
        .fu_busy       (fu_busy),
        .rs_empty      (rs_empty)
    );

    typedef struct {
        logic        jalr;
        logic [2:0]  cmp;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic        jalr;
        logic [2:0]  cmp;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  dst;
        logic [3:0]  t1;
        logic [31:0] v1;
        logic [3:0]  t2;
        logic [31:0] v2;
        logic        byp_v;
        logic [3:0]  byp_tag;
        logic [31:0] byp_data;
        logic        wk_v;
        logic [3:0]  wk_tag;
        logic [31:0] wk_data;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    exp_t sb [$];
    exp_t e_mon;
    vec_t vecs [5];
    int   n_chk;
    int   n_err;
    int   n_issued;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every issue against the head of the scoreboard.
    always @(posedge clk) begin
        #1;
        if (rst_n && fu_en) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_issue: fu_tag 0x%0h fu_pc 0x%0h with nothing expected", fu_tag, fu_pc);
            end else begin
                e_mon = sb.pop_front();
                chk("fu_tag",      32'(fu_tag),      32'(e_mon.tag));
                chk("fu_pc",       fu_pc,            e_mon.pc);
                chk("fu_imm",      fu_imm,           e_mon.imm);
                chk("fu_rs1_data", fu_rs1_data,      e_mon.rs1);
                chk("fu_rs2_data", fu_rs2_data,      e_mon.rs2);
                chk("fu_jalr",     32'(fu_jalr),     32'(e_mon.jalr));
                chk("fu_cmp_ctrl", 32'(fu_cmp_ctrl), 32'(e_mon.cmp));
            end
            n_issued++;
        end
    end

    task automatic clear_inputs();
        disp_valid    = 1'b0;
        disp_jalr     = 1'b0;
        disp_cmp_ctrl = 3'd0;
        disp_imm      = 32'd0;
        disp_pc       = 32'd0;
        disp_dst_tag  = 4'd0;
        disp_rs1_tag  = 4'd0;
        disp_rs1_val  = 32'd0;
        disp_rs2_tag  = 4'd0;
        disp_rs2_val  = 32'd0;
        cdb_valid     = 1'b0;
        cdb_tag       = 4'd0;
        cdb_data      = 32'd0;
    endtask

    task automatic drive_disp(input logic jalr, input logic [2:0] cmp, input logic [31:0] imm,
                              input logic [31:0] pc, input logic [3:0] dst,
                              input logic [3:0] t1, input logic [31:0] v1,
                              input logic [3:0] t2, input logic [31:0] v2);
        disp_valid    = 1'b1;
        disp_jalr     = jalr;
        disp_cmp_ctrl = cmp;
        disp_imm      = imm;
        disp_pc       = pc;
        disp_dst_tag  = dst;
        disp_rs1_tag  = t1;
        disp_rs1_val  = v1;
        disp_rs2_tag  = t2;
        disp_rs2_val  = v2;
    endtask

    task automatic push_exp(input logic jalr, input logic [2:0] cmp, input logic [31:0] rs1,
                            input logic [31:0] rs2, input logic [31:0] imm,
                            input logic [31:0] pc, input logic [3:0] tag);
        exp_t e;
        e.jalr = jalr;
        e.cmp  = cmp;
        e.rs1  = rs1;
        e.rs2  = rs2;
        e.imm  = imm;
        e.pc   = pc;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    function automatic vec_t mkv(input logic jalr, input logic [2:0] cmp, input logic [31:0] imm,
                                 input logic [31:0] pc, input logic [3:0] dst,
                                 input logic [3:0] t1, input logic [31:0] v1,
                                 input logic [3:0] t2, input logic [31:0] v2,
                                 input logic byp_v, input logic [3:0] byp_tag, input logic [31:0] byp_data,
                                 input logic wk_v, input logic [3:0] wk_tag, input logic [31:0] wk_data,
                                 input logic [31:0] exp1, input logic [31:0] exp2);
        vec_t v;
        v.jalr = jalr;   v.cmp = cmp;   v.imm = imm;   v.pc = pc;   v.dst = dst;
        v.t1 = t1;       v.v1 = v1;     v.t2 = t2;     v.v2 = v2;
        v.byp_v = byp_v; v.byp_tag = byp_tag; v.byp_data = byp_data;
        v.wk_v = wk_v;   v.wk_tag = wk_tag;   v.wk_data = wk_data;
        v.exp1 = exp1;   v.exp2 = exp2;
        return v;
    endfunction

    // Count rising edges until fu_en is seen (bounded).
    task automatic wait_issue(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!fu_en && lat < 8);
    endtask

    // Wait until the monitor has seen `target` issues (bounded).
    task automatic wait_count(input int target, input string name);
        int t;
        t = 0;
        while (n_issued < target && t < 20) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk(name, 32'(n_issued), 32'(target));
    endtask

    task automatic pulse_done();
        @(negedge clk);
        fu_done = 1'b1;
        @(negedge clk);
        fu_done = 1'b0;
    endtask

    // One table entry: dispatch, optional late wakeup, issue one cycle after readiness.
    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        chk("vec_disp_ready", 32'(disp_ready), 32'd1);
        drive_disp(v.jalr, v.cmp, v.imm, v.pc, v.dst, v.t1, v.v1, v.t2, v.v2);
        cdb_valid = v.byp_v;
        cdb_tag   = v.byp_tag;
        cdb_data  = v.byp_data;
        push_exp(v.jalr, v.cmp, v.exp1, v.exp2, v.imm, v.pc, v.dst);
        @(negedge clk);
        clear_inputs();
        if (v.wk_v) begin
            @(posedge clk);
            #1;
            chk("vec_no_issue_before_wakeup", 32'(fu_en), 32'd0);
            @(negedge clk);
            cdb_valid = 1'b1;
            cdb_tag   = v.wk_tag;
            cdb_data  = v.wk_data;
            @(negedge clk);
            clear_inputs();
        end
        wait_issue(lat);
        chk("vec_issue_latency", 32'(lat), 32'd1);
        chk("vec_busy_after_issue", 32'(fu_busy), 32'd1);
        pulse_done();
        chk("vec_busy_after_done", 32'(fu_busy), 32'd0);
        chk("vec_rs_empty", 32'(rs_empty), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        n_chk    = 0;
        n_err    = 0;
        n_issued = 0;
        rst_n    = 1'b0;
        fu_done  = 1'b0;
        flush    = 1'b0;
        clear_inputs();

        // Table: JAL, BEQ with late wakeup, BNE with dispatch bypass, JALR, BLTU with wakeup.
        vecs[0] = mkv(1'b0, 3'd0, 32'h20, 32'h100, 4'd3, 4'd0, 32'd0, 4'd0, 32'd0,
                      1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
        vecs[1] = mkv(1'b0, 3'd1, 32'h40, 32'h200, 4'd4, 4'd5, 32'hDEAD, 4'd0, 32'h55,
                      1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'h55, 32'h55, 32'h55);
        vecs[2] = mkv(1'b0, 3'd2, 32'h8, 32'h240, 4'd6, 4'd0, 32'h11, 4'd7, 32'hBEEF,
                      1'b1, 4'd7, 32'hAB, 1'b0, 4'd0, 32'd0, 32'h11, 32'hAB);
        vecs[3] = mkv(1'b1, 3'd0, 32'hFFFF_FFFC, 32'h300, 4'd9, 4'd0, 32'h8000_0000, 4'd0, 32'd0,
                      1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'h8000_0000, 32'd0);
        vecs[4] = mkv(1'b0, 3'd5, 32'h10, 32'h400, 4'd2, 4'hF, 32'h0BAD, 4'd0, 32'h1234,
                      1'b0, 4'd0, 32'd0, 1'b1, 4'hF, 32'hFFFF_0000, 32'hFFFF_0000, 32'h1234);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fu_en",      32'(fu_en),      32'd0);
        chk("rst_fu_busy",    32'(fu_busy),    32'd0);
        chk("rst_disp_ready", 32'(disp_ready), 32'd1);
        chk("rst_rs_empty",   32'(rs_empty),   32'd1);
        chk("rst_fu_pc",      fu_pc,           32'd0);
        chk("rst_fu_rs1",     fu_rs1_data,     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Age order: X in flight, then A (waits tag 2), B, C ready -> B, A, C.
        base = n_issued;
        @(negedge clk);
        drive_disp(1'b0, 3'd0, 32'h4, 32'hE00, 4'hE, 4'd0, 32'd0, 4'd0, 32'd0);
        push_exp(1'b0, 3'd0, 32'd0, 32'd0, 32'h4, 32'hE00, 4'hE);
        @(negedge clk);
        drive_disp(1'b0, 3'd1, 32'hA, 32'hA00, 4'd1, 4'd2, 32'd0, 4'd0, 32'h22);
        @(negedge clk);
        drive_disp(1'b0, 3'd2, 32'hB, 32'hB00, 4'd2, 4'd0, 32'hB1, 4'd0, 32'hB2);
        @(negedge clk);
        drive_disp(1'b0, 3'd3, 32'hC, 32'hC00, 4'd3, 4'd0, 32'hC1, 4'd0, 32'hC2);
        push_exp(1'b0, 3'd2, 32'hB1, 32'hB2, 32'hB, 32'hB00, 4'd2);
        push_exp(1'b0, 3'd1, 32'h22, 32'h22, 32'hA, 32'hA00, 4'd1);
        push_exp(1'b0, 3'd3, 32'hC1, 32'hC2, 32'hC, 32'hC00, 4'd3);
        @(negedge clk);
        clear_inputs();
        chk("age_busy_with_waiters", 32'(fu_busy),    32'd1);
        chk("age_rs_not_empty",      32'(rs_empty),   32'd0);
        chk("age_disp_ready_3_used", 32'(disp_ready), 32'd1);
        wait_count(base + 1, "age_issue_x");
        pulse_done();
        wait_count(base + 2, "age_issue_b");
        // Wakeup of A and fu_done in the same cycle.
        @(negedge clk);
        cdb_valid = 1'b1;
        cdb_tag   = 4'd2;
        cdb_data  = 32'h22;
        fu_done   = 1'b1;
        @(negedge clk);
        clear_inputs();
        fu_done = 1'b0;
        wait_count(base + 3, "age_issue_a");
        pulse_done();
        wait_count(base + 4, "age_issue_c");
        pulse_done();
        chk("age_final_busy",  32'(fu_busy),  32'd0);
        chk("age_final_empty", 32'(rs_empty), 32'd1);

        // Full RS, ignored 5th dispatch, flush with an op in flight.
        base = n_issued;
        @(negedge clk);
        drive_disp(1'b0, 3'd0, 32'h0, 32'h600, 4'd6, 4'd0, 32'd0, 4'd0, 32'd0);
        push_exp(1'b0, 3'd0, 32'd0, 32'd0, 32'h0, 32'h600, 4'd6);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_disp(1'b0, 3'd1, 32'h1, 32'h610 + 32'(k), 4'd7 + 4'(k), 4'hA + 4'(k), 32'd0, 4'd0, 32'd0);
        end
        @(negedge clk);
        chk("full_disp_ready", 32'(disp_ready), 32'd0);
        chk("full_busy",       32'(fu_busy),    32'd1);
        drive_disp(1'b0, 3'd0, 32'h5, 32'h650, 4'h5, 4'd0, 32'd0, 4'd0, 32'd0);
        @(negedge clk);
        clear_inputs();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_rs_empty",   32'(rs_empty),   32'd1);
        chk("flush_disp_ready", 32'(disp_ready), 32'd1);
        chk("flush_keeps_busy", 32'(fu_busy),    32'd1);
        cdb_valid = 1'b1;
        cdb_tag   = 4'hA;
        cdb_data  = 32'h77;
        @(negedge clk);
        clear_inputs();
        chk("flush_still_busy", 32'(fu_busy), 32'd1);
        pulse_done();
        repeat (4) @(negedge clk);
        chk("flush_no_stale_issue", 32'(n_issued), 32'(base + 1));
        chk("flush_idle_busy",      32'(fu_busy),  32'd0);

        // Flush in the issue cycle: the pulse still happens.
        base = n_issued;
        @(negedge clk);
        drive_disp(1'b0, 3'd4, 32'h70, 32'h700, 4'hB, 4'd0, 32'h1, 4'd0, 32'h2);
        push_exp(1'b0, 3'd4, 32'h1, 32'h2, 32'h70, 32'h700, 4'hB);
        @(negedge clk);
        clear_inputs();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_count(base + 1, "flush_cycle_issue");
        chk("flush_cycle_busy",  32'(fu_busy),  32'd1);
        chk("flush_cycle_empty", 32'(rs_empty), 32'd1);
        pulse_done();

        // Asynchronous reset while BUSY with three waiting entries.
        base = n_issued;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_disp(1'b0, 3'd1, 32'h2, 32'h800 + 32'(k), 4'd1 + 4'(k), 4'h8 + 4'(k), 32'd0, 4'd0, 32'd0);
        end
        @(negedge clk);
        drive_disp(1'b1, 3'd0, 32'h90, 32'h900, 4'hC, 4'd0, 32'h9, 4'd0, 32'd0);
        push_exp(1'b1, 3'd0, 32'h9, 32'd0, 32'h90, 32'h900, 4'hC);
        @(negedge clk);
        clear_inputs();
        @(posedge clk);
        #3;
        chk("pre_reset_fu_en",   32'(fu_en),    32'd1);
        chk("pre_reset_empty",   32'(rs_empty), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_fu_en",      32'(fu_en),      32'd0);
        chk("async_rst_fu_busy",    32'(fu_busy),    32'd0);
        chk("async_rst_rs_empty",   32'(rs_empty),   32'd1);
        chk("async_rst_disp_ready", 32'(disp_ready), 32'd1);
        chk("async_rst_fu_pc",      fu_pc,           32'd0);
        chk("async_rst_fu_tag",     32'(fu_tag),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_no_issue", 32'(n_issued), 32'(base + 1));
        chk("sb_drained",        32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
